// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory handshake plus the decoder-facing
// instruction register and redirect inputs.
//   master : the fetch unit (drives imem request and the instruction register)
//   slave  : the environment (memory + decoder/BCE)
// Signals:
//   imem_req/imem_addr      fetch request and address (= pc)
//   imem_ready              memory accepts the request this cycle
//   imem_rvalid/imem_rdata  returned instruction word
//   instr/instr_valid       instruction register and its occupancy flag
//   instr_pc/link_pc        address of instr and instr address + 4
//   dec_ready               decode consumes instr this cycle
//   jump_en/pc_mux_sel      J/Jal/Jr/Jalr redirect and its flavour
//   rs_value                register target for Jr/Jalr
//   branch_taken            branch outcome for the held instruction
//   fetch_err               misaligned-target trap flag
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] link_pc;
  logic        dec_ready;
  logic        jump_en;
  logic [1:0]  pc_mux_sel;
  logic [31:0] rs_value;
  logic        branch_taken;
  logic        fetch_err;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, instr_pc, link_pc, fetch_err,
    input  imem_ready, imem_rvalid, imem_rdata, dec_ready, jump_en, pc_mux_sel,
           rs_value, branch_taken
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, instr_pc, link_pc, fetch_err,
    output imem_ready, imem_rvalid, imem_rdata, dec_ready, jump_en, pc_mux_sel,
           rs_value, branch_taken
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, requests one word at a time from instruction
// memory, holds it in the instruction register until decode takes it, then
// computes the next PC from the jump/branch redirect inputs.
// Ports:
//   clk_i   rising-edge clock
//   rst_i   synchronous active-high reset
//   bus     instr_fetch_unit_if.master (memory handshake + decoder side)
// Parameter:
//   RESET_PC  PC loaded on reset, first fetch address
// Optional feature (macro IFU_ALIGN_CHECK_EN):
//   defined   : a misaligned next PC at handoff traps into S_ERR with a sticky
//               fetch_err; fetching stops until reset
//   undefined : next PC low bits are forced to 00 and fetch_err is tied 0
//
// state  | meaning
// S_REQ  | imem_req high with imem_addr = pc, waiting for imem_ready
// S_WAIT | request granted, waiting for imem_rvalid
// S_HOLD | instr valid, waiting for decode to consume it
// S_ERR  | misaligned target trapped (only with IFU_ALIGN_CHECK_EN)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  instr_fetch_unit_if.master bus
);

`ifdef IFU_ALIGN_CHECK_EN
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_ERR} state_e;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;
`endif

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        instr_valid_q;
  logic        imem_req_q;
  logic        fetch_err_q;

  logic [31:0] link_pc;
  logic [31:0] br_off;
  logic [31:0] next_pc_d;

  // Jal/Jalr differ from J/Jr only in the GPR write, which decode handles
  logic        unused_sel0;
  assign unused_sel0 = bus.pc_mux_sel[0];

  assign link_pc = instr_pc_q + 32'd4;
  assign br_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    next_pc_d = link_pc;
    if (bus.jump_en) begin
      next_pc_d = bus.pc_mux_sel[1] ? bus.rs_value
                                    : {link_pc[31:28], instr_q[25:0], 2'b00};
    end else if (bus.branch_taken) begin
      next_pc_d = link_pc + br_off;
    end
  end

`ifndef IFU_ALIGN_CHECK_EN
  logic [1:0] unused_pc_lsb;
  assign unused_pc_lsb = next_pc_d[1:0];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b1;
      fetch_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (bus.imem_ready) begin
            state_q    <= S_WAIT;
            imem_req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            instr_q       <= bus.imem_rdata;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            state_q       <= S_HOLD;
          end
        end
        S_HOLD: begin
          // instr_valid is always set here, so dec_ready alone marks the handoff
          if (bus.dec_ready) begin
            instr_valid_q <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
            if (next_pc_d[1:0] != 2'b00) begin
              state_q     <= S_ERR;
              fetch_err_q <= 1'b1;
            end else begin
              pc_q       <= next_pc_d;
              state_q    <= S_REQ;
              imem_req_q <= 1'b1;
            end
`else
            pc_q       <= {next_pc_d[31:2], 2'b00};
            state_q    <= S_REQ;
            imem_req_q <= 1'b1;
`endif
          end
        end
`ifdef IFU_ALIGN_CHECK_EN
        S_ERR: state_q <= S_ERR;
`endif
        default: state_q <= S_REQ;
      endcase
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.link_pc     = link_pc;
`ifdef IFU_ALIGN_CHECK_EN
  assign bus.fetch_err   = fetch_err_q;
`else
  assign bus.fetch_err   = 1'b0;
  logic unused_err;
  assign unused_err = fetch_err_q;
`endif

endmodule
